// File: rtl/demux_tree_pkg.sv
// Shared encodings and types for the registered 1-to-4 stream distributor.
package demux_tree_pkg;

  localparam logic SEL_LEFT = 1'b1;
  localparam logic SEL_A    = 1'b1;
  localparam logic SEL_C    = 1'b1;

  typedef enum logic {
    NODE_EMPTY = 1'b0,
    NODE_FULL  = 1'b1
  } node_state_e;

  // Child selects carried by the root alongside the payload.
  typedef struct packed {
    logic sel2;
    logic sel3;
  } root_side_t;

endpackage

// File: rtl/demux_tree_if.sv
// Stream-side bundle of the demux tree: one input port and four leaf ports.
interface demux_tree_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             sel1;
  logic             sel2;
  logic             sel3;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic [WIDTH-1:0] c_data;
  logic [WIDTH-1:0] d_data;
  logic             a_valid;
  logic             b_valid;
  logic             c_valid;
  logic             d_valid;
  logic             a_ready;
  logic             b_ready;
  logic             c_ready;
  logic             d_ready;

  logic             busy;

  modport master (
    output in_data, sel1, sel2, sel3, in_valid,
    output a_ready, b_ready, c_ready, d_ready,
    input  in_ready,
    input  a_data, b_data, c_data, d_data,
    input  a_valid, b_valid, c_valid, d_valid,
    input  busy
  );

  modport slave (
    input  in_data, sel1, sel2, sel3, in_valid,
    input  a_ready, b_ready, c_ready, d_ready,
    output in_ready,
    output a_data, b_data, c_data, d_data,
    output a_valid, b_valid, c_valid, d_valid,
    output busy
  );

endinterface

// File: rtl/demux_tree_node.sv
// Single-entry registered 1-to-2 split node; bit 0 of the stored sideband
// steers the word to the hi output (1) or the lo output (0).
module demux_node
  import demux_tree_pkg::*;
#(
  parameter int DW = 8,
  parameter int SW = 1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          up_valid,
  output logic          up_ready,
  input  logic [DW-1:0] up_data,
  input  logic [SW-1:0] up_side,

  output logic          hi_valid,
  input  logic          hi_ready,
  output logic          lo_valid,
  input  logic          lo_ready,
  output logic [DW-1:0] dn_data,

  output logic          full
);

  node_state_e   state_q, state_d;
  logic [DW-1:0] data_q,  data_d;
  logic [SW-1:0] side_q,  side_d;

  logic sel_hi;
  logic pop;
  logic accept;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    sel_hi   = side_q[0];
    pop      = (state_q == NODE_FULL) && (sel_hi ? hi_ready : lo_ready);
    // Ready chains combinationally through the downstream readys, so a full
    // node can refill on the same edge it drains.
    up_ready = (state_q == NODE_EMPTY) || pop;
    accept   = up_valid && up_ready;

    state_d  = state_q;
    data_d   = data_q;
    side_d   = side_q;

    if (accept) begin
      state_d = NODE_FULL;
      data_d  = up_data;
      side_d  = up_side;
    end else if (pop) begin
      state_d = NODE_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  // NOTE: the payload register is reset too, since leaf data must read 0 out
  // of reset; it is a single entry, not a memory array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NODE_EMPTY;
      data_q  <= '0;
      side_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      side_q  <= side_d;
    end
  end

  assign full     = (state_q == NODE_FULL);
  assign hi_valid = full &&  sel_hi;
  assign lo_valid = full && !sel_hi;
  assign dn_data  = data_q;

endmodule

// File: rtl/demux_tree.sv
// Registered 1-to-4 stream distributor: a root split feeding left (a/b) and
// right (c/d) split nodes.
module demux_tree
  import demux_tree_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_tree_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    root_side_t       side;
  } root_entry_t;

  root_entry_t root_in;
  root_entry_t root_out;

  logic l_valid, l_ready;
  logic r_valid, r_ready;
  logic root_full, left_full, right_full;
  logic [WIDTH-1:0] left_data, right_data;

  always_comb begin
    root_in           = '0;
    root_in.data      = bus.in_data;
    root_in.side.sel2 = bus.sel2;
    root_in.side.sel3 = bus.sel3;
  end

  demux_node #(.DW($bits(root_entry_t)), .SW(1)) u_root (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .up_data  (root_in),
    .up_side  (bus.sel1 == SEL_LEFT),
    .hi_valid (l_valid),
    .hi_ready (l_ready),
    .lo_valid (r_valid),
    .lo_ready (r_ready),
    .dn_data  (root_out),
    .full     (root_full)
  );

  demux_node #(.DW(WIDTH), .SW(1)) u_left (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (l_valid),
    .up_ready (l_ready),
    .up_data  (root_out.data),
    .up_side  (root_out.side.sel2 == SEL_A),
    .hi_valid (bus.a_valid),
    .hi_ready (bus.a_ready),
    .lo_valid (bus.b_valid),
    .lo_ready (bus.b_ready),
    .dn_data  (left_data),
    .full     (left_full)
  );

  demux_node #(.DW(WIDTH), .SW(1)) u_right (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_valid (r_valid),
    .up_ready (r_ready),
    .up_data  (root_out.data),
    .up_side  (root_out.side.sel3 == SEL_C),
    .hi_valid (bus.c_valid),
    .hi_ready (bus.c_ready),
    .lo_valid (bus.d_valid),
    .lo_ready (bus.d_ready),
    .dn_data  (right_data),
    .full     (right_full)
  );

  assign bus.a_data = left_data;
  assign bus.b_data = left_data;
  assign bus.c_data = right_data;
  assign bus.d_data = right_data;
  assign bus.busy   = root_full || left_full || right_full;

endmodule

// File: tb/tb_demux_tree.sv
// Self-checking bench for demux_tree: per-leaf FIFO scoreboard plus directed
// literal expectations.
module tb_demux_tree;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_tree_if #(.WIDTH(8)) bus ();

  demux_tree #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] d;
    int         e;
  } ent_t;

  ent_t q[4][$];
  int   inflight = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic lv(input int i);
    case (i)
      0: return bus.a_valid;
      1: return bus.b_valid;
      2: return bus.c_valid;
      default: return bus.d_valid;
    endcase
  endfunction

  function automatic logic lr(input int i);
    case (i)
      0: return bus.a_ready;
      1: return bus.b_ready;
      2: return bus.c_ready;
      default: return bus.d_ready;
    endcase
  endfunction

  function automatic logic [7:0] ld(input int i);
    case (i)
      0: return bus.a_data;
      1: return bus.b_data;
      2: return bus.c_data;
      default: return bus.d_data;
    endcase
  endfunction

  // Leaf index from the select rule: sel1 picks a/b vs c/d, then sel2 or sel3.
  function automatic int leaf_of(input logic s1, input logic s2, input logic s3);
    if (s1) return s2 ? 0 : 1;
    return s3 ? 2 : 3;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: observes handshakes at the falling edge, i.e. the transfers
  // that the next rising edge will commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) q[i].delete();
      inflight = 0;
    end else begin
      check("busy", {31'd0, bus.busy}, {31'd0, inflight != 0});
      for (int i = 0; i < 4; i++) begin
        if (lv(i)) begin
          if (q[i].size() == 0) begin
            check($sformatf("leaf%0d_spurious_valid", i), 32'd1, 32'd0);
          end else begin
            check($sformatf("leaf%0d_data", i), {24'd0, ld(i)}, {24'd0, q[i][0].d});
            if (lr(i)) begin
              check($sformatf("leaf%0d_latency_ge2", i),
                    {31'd0, (cyc + 1 - q[i][0].e) >= 2}, 32'd1);
              void'(q[i].pop_front());
              inflight--;
            end
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q[leaf_of(bus.sel1, bus.sel2, bus.sel3)].push_back('{d: bus.in_data, e: cyc + 1});
        inflight++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a word for leaf 0..3 (a..d); the unused select is set to the
  // opposite polarity to show it is ignored.
  task automatic drive(input logic v, input logic [7:0] d, input int leaf);
    bus.in_valid = v;
    bus.in_data  = d;
    case (leaf)
      0: begin bus.sel1 = 1'b1; bus.sel2 = 1'b1; bus.sel3 = 1'b0; end
      1: begin bus.sel1 = 1'b1; bus.sel2 = 1'b0; bus.sel3 = 1'b1; end
      2: begin bus.sel1 = 1'b0; bus.sel3 = 1'b1; bus.sel2 = 1'b0; end
      default: begin bus.sel1 = 1'b0; bus.sel3 = 1'b0; bus.sel2 = 1'b1; end
    endcase
  endtask

  task automatic set_ready(input logic [3:0] r);
    {bus.a_ready, bus.b_ready, bus.c_ready, bus.d_ready} = r;
  endtask

  task automatic drain(input string name);
    bus.in_valid = 1'b0;
    set_ready(4'b1111);
    for (int i = 0; i < 20 && inflight != 0; i++) step();
    check(name, inflight, 32'd0);
  endtask

  logic [3:0] valids;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.sel1 = 1'b0; bus.sel2 = 1'b0; bus.sel3 = 1'b0;
    set_ready(4'b1111);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valids", {28'd0, bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_data", {bus.a_data, bus.b_data, bus.c_data, bus.d_data}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();

    // Single word 0x5A to a
    drive(1'b1, 8'h5A, 0);
    @(negedge clk);
    check("single_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("single_a_not_yet", {31'd0, bus.a_valid}, 32'd0);
    step();
    @(negedge clk);
    check("single_a_valid", {31'd0, bus.a_valid}, 32'd1);
    check("single_a_data", {24'd0, bus.a_data}, 32'h5A);
    check("single_bcd_idle", {29'd0, bus.b_valid, bus.c_valid, bus.d_valid}, 32'd0);
    step();
    @(negedge clk);
    check("single_a_gone", {31'd0, bus.a_valid}, 32'd0);
    check("single_busy_low", {31'd0, bus.busy}, 32'd0);
    step();

    // Back-to-back 0x01..0x04 to a, b, c, d
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(i + 1), i);
      @(negedge clk);
      check("stream_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i >= 2) begin
        check("stream_leaf_valid", {31'd0, lv(i - 2)}, 32'd1);
        check("stream_leaf_data", {24'd0, ld(i - 2)}, 32'(i - 1));
      end
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_c_data", {23'd0, bus.c_valid, bus.c_data}, 32'h103);
    check("stream_d_pending", {31'd0, bus.d_valid}, 32'd0);
    step();
    @(negedge clk);
    check("stream_d_data", {23'd0, bus.d_valid, bus.d_data}, 32'h104);
    step();
    drain("stream_drain");

    // Stall on d: two words buffered, third blocked
    set_ready(4'b1110);
    drive(1'b1, 8'h10, 3);
    @(negedge clk);
    check("stall_acc0", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b1, 8'h11, 3);
    @(negedge clk);
    check("stall_acc1", {31'd0, bus.in_ready}, 32'd1);
    step();
    drive(1'b1, 8'h12, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_blocked", {31'd0, bus.in_ready}, 32'd0);
      check("stall_d_hold", {23'd0, bus.d_valid, bus.d_data}, 32'h110);
      step();
    end
    bus.d_ready = 1'b1;
    @(negedge clk);
    check("stall_release_ready", {31'd0, bus.in_ready}, 32'd1);
    check("stall_first_out", {24'd0, bus.d_data}, 32'h10);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stall_second_out", {23'd0, bus.d_valid, bus.d_data}, 32'h111);
    step();
    @(negedge clk);
    check("stall_third_out", {23'd0, bus.d_valid, bus.d_data}, 32'h112);
    step();
    drain("stall_drain");

    // Head-of-line blocking: a-word waits behind stalled d-words
    set_ready(4'b1110);
    drive(1'b1, 8'h20, 3);
    step();
    drive(1'b1, 8'h21, 3);
    step();
    drive(1'b1, 8'h30, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hol_blocked", {30'd0, bus.in_ready, bus.a_valid}, 32'd0);
      step();
    end
    bus.d_ready = 1'b1;
    @(negedge clk);
    check("hol_unblocked", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    begin
      int n = 0;
      @(negedge clk);
      while (!bus.a_valid && n < 10) begin
        step();
        @(negedge clk);
        n++;
      end
      check("hol_a_data", {23'd0, bus.a_valid, bus.a_data}, 32'h130);
    end
    step();
    drain("hol_drain");

    // Reset with three words in flight
    set_ready(4'b1010);
    drive(1'b1, 8'h40, 1);
    step();
    drive(1'b1, 8'h41, 3);
    step();
    drive(1'b1, 8'h42, 0);
    @(negedge clk);
    check("inflight_acc2", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("inflight_state", {29'd0, bus.busy, bus.b_valid, bus.d_valid}, 32'h7);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valids", {28'd0, bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_data", {bus.a_data, bus.b_data, bus.c_data, bus.d_data}, 32'd0);
    set_ready(4'b1111);
    step();
    rst_n = 1'b1;
    valids = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valids = valids | {bus.a_valid, bus.b_valid, bus.c_valid, bus.d_valid};
      step();
    end
    check("no_stale_word", {28'd0, valids}, 32'd0);

    // Random traffic against the scoreboard
    begin
      int acc = 0;
      int n   = 0;
      while (acc < 1000 && n < 20000) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_data  = 8'($urandom);
        bus.sel1     = 1'($urandom);
        bus.sel2     = 1'($urandom);
        bus.sel3     = 1'($urandom);
        bus.a_ready  = ($urandom_range(0, 9) < 7);
        bus.b_ready  = ($urandom_range(0, 9) < 7);
        bus.c_ready  = ($urandom_range(0, 9) < 7);
        bus.d_ready  = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) acc++;
        step();
        n++;
      end
      check("random_accepted", {31'd0, acc >= 1000}, 32'd1);
    end
    drain("random_drain");
    for (int i = 0; i < 4; i++)
      check($sformatf("random_leaf%0d_empty", i), q[i].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
